// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
// Miss-handling sequencer for a direct-mapped cache with 8-word blocks.
// On a miss it stalls the pipeline, streams eight word reads to a pipelined
// memory, writes each returned word into the data array, then writes
// valid+tag into the metadata array and releases the stall.
//
// Optional feature macro: CACHE_MISS_CNT_EN
//   When defined, the miss_count port exists and counts IDLE->FILL
//   transitions, saturating at 16'hFFFF.
//
// Ports
//   clk                in   system clock, rising edge
//   rst                in   asynchronous, active-low reset
//   miss_detected      in   cache reports a miss on an enabled access
//   miss_address       in   byte address of the missing access
//   memory_data        in   word returned by memory
//   memory_data_valid  in   memory_data valid this cycle
//   fsm_busy           out  stall request to the pipeline while filling
//   memory_read_en     out  read request to memory this cycle
//   memory_address     out  byte address of the current request
//   write_data_array   out  write fill_data into data-array word word_num
//   write_tag_array    out  write {valid,tag} of the latched block
//   word_num           out  word index within the block for the data write
//   fill_data          out  data to the cache, follows memory_data
//   miss_count         out  (CACHE_MISS_CNT_EN only) saturating miss counter
// -----------------------------------------------------------------------------
module cache_fill_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              memory_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [2:0]        word_num,
    output logic [DATA_W-1:0] fill_data
`ifdef CACHE_MISS_CNT_EN
    ,
    output logic [15:0]       miss_count
`endif
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        req_cnt_q, req_cnt_d;
    logic [2:0]        rcv_cnt_q, rcv_cnt_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] blk_addr;

    // Block-aligned byte address: 8 words x 2 bytes = 16 bytes per block.
    assign blk_addr = miss_address & ~ADDR_W'(15);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        req_cnt_d = req_cnt_q;
        rcv_cnt_d = rcv_cnt_q;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    // The first request is registered here so it is on the
                    // memory port during the first FILL cycle.
                    state_d   = FILL;
                    base_d    = blk_addr;
                    req_cnt_d = 4'd1;
                    rcv_cnt_d = 3'd0;
                    rd_en_d   = 1'b1;
                    addr_d    = blk_addr;
                    busy_d    = 1'b1;
                end
            end
            FILL: begin
                if (req_cnt_q < 4'(BLK_WORDS)) begin
                    rd_en_d   = 1'b1;
                    // base has four zero LSBs, so this add never carries out.
                    addr_d    = base_q + ADDR_W'({req_cnt_q[2:0], 1'b0});
                    req_cnt_d = req_cnt_q + 4'd1;
                end
                // Responses are counted rather than timed, so gaps are fine.
                if (memory_data_valid) begin
                    rcv_cnt_d = rcv_cnt_q + 3'd1;
                    if (rcv_cnt_q == 3'd7) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        rd_en_d = 1'b0;
                        addr_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
        end
    end

    assign fsm_busy       = busy_q;
    assign memory_read_en = rd_en_q;
    assign memory_address = addr_q;
    assign fill_data      = memory_data;

    // Write strobes follow the response in the same cycle; gating with the
    // state keeps stray responses in IDLE (e.g. after a reset) harmless.
    assign write_data_array = (state_q == FILL) && memory_data_valid;
    assign write_tag_array  = write_data_array && (rcv_cnt_q == 3'd7);
    assign word_num         = (state_q == FILL) ? rcv_cnt_q : 3'd0;

`ifdef CACHE_MISS_CNT_EN
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && miss_detected && (miss_cnt_q != 16'hFFFF))
            miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) miss_cnt_q <= '0;
        else      miss_cnt_q <= miss_cnt_d;
    end

    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_ctrl
// Directed + randomized bench for cache_fill_ctrl. A behavioural memory
// (queue of response-ready times) drives the fills, and the expected request
// addresses, write strobes, word indices and tag timing are derived from the
// block base address and counts of requests/responses seen so far.
// -----------------------------------------------------------------------------
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic [15:0] memory_data = '0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  word_num;
    logic [15:0] fill_data;
`ifdef CACHE_MISS_CNT_EN
    logic [15:0] miss_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fills  = 0;

    cache_fill_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .word_num          (word_num),
        .fill_data         (fill_data)
`ifdef CACHE_MISS_CNT_EN
        ,
        .miss_count        (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},  32'(fsm_busy), 0);
        chk({tag, "_rd_en"}, 32'(memory_read_en), 0);
        chk({tag, "_wr"},    32'(write_data_array), 0);
        chk({tag, "_tag"},   32'(write_tag_array), 0);
    endtask

    // Cycle 0 of a fill: miss presented while the controller is idle.
    task automatic start_miss(input logic [15:0] a);
        @(posedge clk); #1;
        miss_detected     = 1'b1;
        miss_address      = a;
        memory_data_valid = 1'b0;
        #4;
        chk("start_idle_busy", 32'(fsm_busy), 0);
        n_fills++;
    endtask

    // Runs FILL cycles 1.. until the 8th response, then the busy-drop cycle.
    // gap: idle cycles forced between consecutive responses.
    // noise: random miss_detected pulses during the fill.
    // chain: present a new miss (next_a) in the busy-drop cycle.
    task automatic do_fill(input logic [15:0] a, input int gap, input bit noise,
                           input bit chain, input logic [15:0] next_a);
        logic [15:0] base;
        int nreq, nrcv, cyc, next_ok, first_wr, tag_cyc;
        int rdy_q[$];
        base = a & 16'hFFF0;
        nreq = 0; nrcv = 0; cyc = 0; next_ok = 0; first_wr = -1; tag_cyc = -1;
        while (nrcv < 8 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            miss_detected     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            miss_address      = 16'($urandom);
            memory_data_valid = 1'b0;
            if (rdy_q.size() > 0 && rdy_q[0] <= cyc && cyc >= next_ok) begin
                void'(rdy_q.pop_front());
                memory_data_valid = 1'b1;
                memory_data       = 16'($urandom);
                next_ok           = cyc + 1 + gap;
            end
            #4;
            chk("busy", 32'(fsm_busy), 1);
            if (nreq < 8) begin
                chk("rd_en", 32'(memory_read_en), 1);
                chk("addr", 32'(memory_address), 32'(base + 16'(2 * nreq)));
                rdy_q.push_back(cyc + 4);
                nreq++;
            end else begin
                chk("rd_en_done", 32'(memory_read_en), 0);
            end
            chk("wr_data", 32'(write_data_array), 32'(memory_data_valid));
            chk("wr_tag", 32'(write_tag_array), 32'(memory_data_valid && nrcv == 7));
            chk("fill_data", 32'(fill_data), 32'(memory_data));
            if (memory_data_valid) begin
                chk("word_num", 32'(word_num), 32'(nrcv));
                if (first_wr < 0) first_wr = cyc;
                if (nrcv == 7) tag_cyc = cyc;
                nrcv++;
            end
        end
        if (nrcv < 8) chk("fill_timeout", 32'(nrcv), 8);
        @(posedge clk); #1;
        miss_detected     = chain;
        miss_address      = next_a;
        memory_data_valid = 1'b0;
        #4;
        chk_quiet("drop");
        if (chain) n_fills++;
        if (gap == 0) begin
            chk("first_wr_cycle", 32'(first_wr), 5);
            chk("tag_cycle", 32'(tag_cyc), 12);
        end
    endtask

    initial begin
        // Reset state
        #3;
        chk_quiet("reset");
        chk("reset_addr", 32'(memory_address), 0);
        chk("reset_word", 32'(word_num), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Responses while idle must not write
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            memory_data_valid = 1'b1;
            memory_data       = 16'($urandom);
            #4;
            chk("idle_valid_wr", 32'(write_data_array), 0);
            chk("idle_valid_tag", 32'(write_tag_array), 0);
            chk("idle_fill_data", 32'(fill_data), 32'(memory_data));
        end

        // Single miss, 4-cycle memory
        start_miss(16'h12A6);
        do_fill(16'h12A6, 0, 1'b0, 1'b0, 16'h0);

        // Top block: no wrap past 0xFFFE
        start_miss(16'hFFFC);
        do_fill(16'hFFFC, 0, 1'b0, 1'b0, 16'h0);

        // Gappy memory
        start_miss(16'h5A5A);
        do_fill(16'h5A5A, 2, 1'b0, 1'b0, 16'h0);

        // Back-to-back with miss noise during the first fill
        start_miss(16'h0040);
        do_fill(16'h0040, 0, 1'b1, 1'b1, 16'h0810);
        do_fill(16'h0810, 0, 1'b0, 1'b0, 16'h0);

        // Randomized fills
        for (int i = 0; i < 4; i++) begin
            logic [15:0] ra;
            ra = 16'($urandom);
            start_miss(ra);
            do_fill(ra, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 16'h0);
        end

`ifdef CACHE_MISS_CNT_EN
        chk("miss_count", 32'(miss_count), 32'(n_fills));
`endif

        // Reset mid-fill (FILL cycle 6)
        start_miss(16'h3450);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            miss_detected     = 1'b0;
            memory_data_valid = (c >= 5);
            memory_data       = 16'($urandom);
            #1;
        end
        chk("pre_rst_wr", 32'(write_data_array), 1);
        chk("pre_rst_word", 32'(word_num), 1);
        rst = 1'b0;
        #1;
        chk_quiet("mid_rst");
        chk("mid_rst_addr", 32'(memory_address), 0);
        chk("mid_rst_word", 32'(word_num), 0);
`ifdef CACHE_MISS_CNT_EN
        chk("mid_rst_miss_count", 32'(miss_count), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            memory_data_valid = 1'b1;
            #4;
            chk_quiet("post_rst");
        end
        memory_data_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
